// File: rtl/complete_arbiter.sv
// Round-robin arbiter that shares the single completion/writeback broadcast
// between the execute pipes. Winner fields are registered one cycle later.

module complete_arbiter_lane #(
  parameter int W = 8
) (
  input  logic         gnt,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  // AND-OR mux slice: only the granted lane contributes to the OR-reduction.
  assign dout = din & {W{gnt}};
endmodule

module complete_arbiter #(
  parameter  int p_num_pipes      = 2,
  parameter  int p_seq_num_bits   = 5,
  parameter  int p_num_phys_regs  = 36,
  localparam int p_phys_addr_bits = $clog2(p_num_phys_regs)
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [p_num_pipes-1:0]                         req_val,
  output logic [p_num_pipes-1:0]                         req_rdy,
  input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]     req_seq_num,
  input  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]   req_preg,
  input  logic [p_num_pipes-1:0][4:0]                    req_waddr,
  input  logic [p_num_pipes-1:0][31:0]                   req_wdata,
  input  logic [p_num_pipes-1:0]                         req_wen,
  output logic                                           complete_val,
  output logic [p_seq_num_bits-1:0]                      complete_seq_num,
  output logic [p_phys_addr_bits-1:0]                    complete_preg,
  output logic [4:0]                                     complete_waddr,
  output logic [31:0]                                    complete_wdata,
  output logic                                           complete_wen
);

  localparam int PTR_W = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;
  localparam int PW    = p_seq_num_bits + p_phys_addr_bits + 5 + 32 + 1;

  logic [PTR_W-1:0]                ptr;
  logic [PTR_W-1:0]                win;
  logic                            found;
  logic                            xfer;
  int                              target;
  logic [p_num_pipes-1:0][PW-1:0]  payload;
  logic [p_num_pipes-1:0][PW-1:0]  masked;
  logic [PW-1:0]                   sel;

  // Scan priority slots k = 0..N-1; slot k maps to pipe (ptr+k) mod N.
  // Constant lane indices only, so the pointer never drives a variable index.
  always_comb begin
    req_rdy = '0;
    win     = '0;
    found   = 1'b0;
    target  = 0;
    for (int k = 0; k < p_num_pipes; k++) begin
      target = int'(ptr) + k;
      if (target >= p_num_pipes) target = target - p_num_pipes;
      for (int i = 0; i < p_num_pipes; i++) begin
        if (!found && req_val[i] && (i == target)) begin
          found      = 1'b1;
          req_rdy[i] = 1'b1;
          win        = PTR_W'(i);
        end
      end
    end
    if (rst) req_rdy = '0;
  end

  assign xfer = |req_rdy;

  for (genvar g = 0; g < p_num_pipes; g++) begin : g_payload
    assign payload[g] = {req_seq_num[g], req_preg[g], req_waddr[g], req_wdata[g], req_wen[g]};
  end

  complete_arbiter_lane #(.W(PW)) u_lane [p_num_pipes-1:0] (
    .gnt  (req_rdy),
    .din  (payload),
    .dout (masked)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < p_num_pipes; i++) sel = sel | masked[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      complete_val <= 1'b0;
      complete_wen <= 1'b0;
    end else begin
      complete_val <= xfer;
      complete_wen <= xfer & sel[0];
      if (xfer) ptr <= (win == PTR_W'(p_num_pipes - 1)) ? '0 : win + PTR_W'(1);
    end
  end

  // Data fields carry no reset; they are only meaningful with complete_val.
  always_ff @(posedge clk) begin
    {complete_seq_num, complete_preg, complete_waddr, complete_wdata} <= sel[PW-1:1];
  end

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed table plus corner sequences for complete_arbiter at N=2 and N=3.

module tb_complete_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=2 instance
  logic [1:0]       v2, r2, wen2;
  logic [1:0][4:0]  seq2, waddr2;
  logic [1:0][5:0]  preg2;
  logic [1:0][31:0] wdata2;
  logic             cv2, cwen2;
  logic [4:0]       cseq2, cwaddr2;
  logic [5:0]       cpreg2;
  logic [31:0]      cwdata2;

  // N=3 instance
  logic [2:0]       v3, r3, wen3;
  logic [2:0][4:0]  seq3, waddr3;
  logic [2:0][5:0]  preg3;
  logic [2:0][31:0] wdata3;
  logic             cv3, cwen3;
  logic [4:0]       cseq3, cwaddr3;
  logic [5:0]       cpreg3;
  logic [31:0]      cwdata3;

  complete_arbiter #(.p_num_pipes(2)) dut2 (
    .clk(clk), .rst(rst), .req_val(v2), .req_rdy(r2), .req_seq_num(seq2),
    .req_preg(preg2), .req_waddr(waddr2), .req_wdata(wdata2), .req_wen(wen2),
    .complete_val(cv2), .complete_seq_num(cseq2), .complete_preg(cpreg2),
    .complete_waddr(cwaddr2), .complete_wdata(cwdata2), .complete_wen(cwen2)
  );

  complete_arbiter #(.p_num_pipes(3)) dut3 (
    .clk(clk), .rst(rst), .req_val(v3), .req_rdy(r3), .req_seq_num(seq3),
    .req_preg(preg3), .req_waddr(waddr3), .req_wdata(wdata3), .req_wen(wen3),
    .complete_val(cv3), .complete_seq_num(cseq3), .complete_preg(cpreg3),
    .complete_waddr(cwaddr3), .complete_wdata(cwdata3), .complete_wen(cwen3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [1:0]       val, wen;
    logic [1:0][4:0]  seq, waddr;
    logic [1:0][5:0]  preg;
    logic [1:0][31:0] wdata;
    logic [1:0]       rdy;
    logic             cval, cwen;
    logic [4:0]       cseq, cwaddr;
    logic [5:0]       cpreg;
    logic [31:0]      cwdata;
  } vec_t;

  function automatic vec_t mk(
    logic [1:0] val, logic [1:0] wen, logic [4:0] s0, logic [4:0] s1,
    logic [5:0] p0, logic [5:0] p1, logic [4:0] a0, logic [4:0] a1,
    logic [31:0] d0, logic [31:0] d1, logic [1:0] rdy, logic cval, logic cwen,
    logic [4:0] cseq, logic [5:0] cpreg, logic [4:0] cwaddr, logic [31:0] cwdata);
    vec_t t;
    t.val = val; t.wen = wen;
    t.seq[0] = s0;   t.seq[1] = s1;
    t.preg[0] = p0;  t.preg[1] = p1;
    t.waddr[0] = a0; t.waddr[1] = a1;
    t.wdata[0] = d0; t.wdata[1] = d1;
    t.rdy = rdy; t.cval = cval; t.cwen = cwen;
    t.cseq = cseq; t.cpreg = cpreg; t.cwaddr = cwaddr; t.cwdata = cwdata;
    return t;
  endfunction

  vec_t tbl[10];

  logic [1:0]  exp_w;
  logic [1:0]  mptr;
  logic [2:0]  exp_rdy3;
  logic        pend;
  logic [4:0]  pend_seq;
  logic        pend_wen;
  int          wait1;

  initial begin
    // Row expectations: rdy for this cycle, complete_* from the previous row.
    tbl[0] = mk(2'b01, 2'b01, 5'd3, 5'd0, 6'd10, 6'd0, 5'd4, 5'd0, 32'hDEADBEEF, 32'h0,
                2'b01, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0, 32'h0);
    tbl[1] = mk(2'b00, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 5'd0, 5'd0, 32'h0, 32'h0,
                2'b00, 1'b1, 1'b1, 5'd3, 6'd10, 5'd4, 32'hDEADBEEF);
    tbl[2] = mk(2'b00, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 5'd0, 5'd0, 32'h0, 32'h0,
                2'b00, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0, 32'h0);
    tbl[3] = mk(2'b10, 2'b00, 5'd0, 5'd7, 6'd0, 6'd20, 5'd0, 5'd9, 32'h0, 32'h12345678,
                2'b10, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0, 32'h0);
    tbl[4] = mk(2'b11, 2'b11, 5'd1, 5'd2, 6'd1, 6'd2, 5'd1, 5'd2, 32'hA0, 32'hB0,
                2'b01, 1'b1, 1'b0, 5'd7, 6'd20, 5'd9, 32'h12345678);
    tbl[5] = mk(2'b11, 2'b11, 5'd3, 5'd4, 6'd3, 6'd4, 5'd3, 5'd4, 32'hA1, 32'hB1,
                2'b10, 1'b1, 1'b1, 5'd1, 6'd1, 5'd1, 32'hA0);
    tbl[6] = mk(2'b11, 2'b10, 5'd5, 5'd6, 6'd5, 6'd6, 5'd5, 5'd6, 32'hA2, 32'hB2,
                2'b01, 1'b1, 1'b1, 5'd4, 6'd4, 5'd4, 32'hB1);
    tbl[7] = mk(2'b11, 2'b11, 5'd8, 5'd9, 6'd8, 6'd9, 5'd8, 5'd9, 32'hA3, 32'hB3,
                2'b10, 1'b1, 1'b0, 5'd5, 6'd5, 5'd5, 32'hA2);
    tbl[8] = mk(2'b00, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 5'd0, 5'd0, 32'h0, 32'h0,
                2'b00, 1'b1, 1'b1, 5'd9, 6'd9, 5'd9, 32'hB3);
    tbl[9] = mk(2'b00, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 5'd0, 5'd0, 32'h0, 32'h0,
                2'b00, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0, 32'h0);

    rst = 1'b1;
    v2 = '0; wen2 = '0; seq2 = '0; preg2 = '0; waddr2 = '0; wdata2 = '0;
    v3 = '0; wen3 = '0; seq3 = '0; preg3 = '0; waddr3 = '0; wdata3 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      v2 = tbl[i].val; wen2 = tbl[i].wen; seq2 = tbl[i].seq;
      preg2 = tbl[i].preg; waddr2 = tbl[i].waddr; wdata2 = tbl[i].wdata;
      @(negedge clk);
      chk($sformatf("row%0d rdy", i), r2, tbl[i].rdy);
      chk($sformatf("row%0d cval", i), cv2, tbl[i].cval);
      chk($sformatf("row%0d cwen", i), cwen2, tbl[i].cwen);
      if (tbl[i].cval) begin
        chk($sformatf("row%0d cseq", i), cseq2, tbl[i].cseq);
        chk($sformatf("row%0d cpreg", i), cpreg2, tbl[i].cpreg);
        chk($sformatf("row%0d cwaddr", i), cwaddr2, tbl[i].cwaddr);
        chk($sformatf("row%0d cwdata", i), cwdata2, tbl[i].cwdata);
      end
      @(posedge clk); #1;
    end

    // Reset mid-operation: move ptr to 1, then reset while both request.
    v2 = 2'b01; seq2[0] = 5'd11; seq2[1] = 5'd12;
    @(posedge clk); #1;
    rst = 1'b1; v2 = 2'b11;
    @(negedge clk);
    chk("rst rdy0", r2, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst rdy1", r2, 2'b00);
    chk("rst cval", cv2, 1'b0);
    chk("rst cwen", cwen2, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post rst cval", cv2, 1'b0);
    chk("post rst rdy", r2, 2'b01);
    @(posedge clk); #1 v2 = 2'b00;
    @(negedge clk);
    chk("post rst grant val", cv2, 1'b1);
    chk("post rst grant seq", cseq2, 5'd11);
    @(posedge clk); #1;

    // N=3 wrap: pipe0 granted, then only pipe2 with ptr=1, then 0 vs 1.
    v3 = 3'b001; seq3[0] = 5'd1;
    @(negedge clk); chk("n3 c1 rdy", r3, 3'b001);
    @(posedge clk); #1 v3 = 3'b100; seq3[2] = 5'd2;
    @(negedge clk); chk("n3 c2 rdy", r3, 3'b100); chk("n3 c2 cseq", cseq3, 5'd1);
    @(posedge clk); #1 v3 = 3'b011; seq3[0] = 5'd3; seq3[1] = 5'd4;
    @(negedge clk); chk("n3 c3 rdy", r3, 3'b001); chk("n3 c3 cseq", cseq3, 5'd2);
    @(posedge clk); #1 seq3[0] = 5'd5; seq3[1] = 5'd6;
    @(negedge clk); chk("n3 c4 rdy", r3, 3'b010); chk("n3 c4 cseq", cseq3, 5'd3);
    @(posedge clk); #1 v3 = 3'b000;
    @(negedge clk); chk("n3 c5 cval", cv3, 1'b1); chk("n3 c5 cseq", cseq3, 5'd6);
    @(posedge clk); #1;

    // Random stress: pipe1 held high, pipes 0/2 random; last grant was pipe1.
    mptr = 2'd2; pend = 1'b0; pend_seq = '0; pend_wen = 1'b0; wait1 = 0;
    for (int c = 0; c < 1000; c++) begin
      v3 = {1'($urandom_range(1)), 1'b1, 1'($urandom_range(1))};
      wen3 = 3'($urandom_range(7));
      for (int i = 0; i < 3; i++) seq3[i] = 5'($urandom_range(31));
      @(negedge clk);
      exp_w = 2'd0;
      for (int k = 2; k >= 0; k--) begin
        int j;
        j = (int'(mptr) + k) % 3;
        if (v3[j]) exp_w = 2'(j);
      end
      exp_rdy3 = 3'b001 << exp_w;
      chk("rand rdy", r3, exp_rdy3);
      chk("rand cval", cv3, pend);
      if (pend) begin
        chk("rand cseq", cseq3, pend_seq);
        chk("rand cwen", cwen3, pend_wen);
      end
      wait1 = (exp_w == 2'd1) ? 0 : wait1 + 1;
      chk("rand fair", wait1 <= 2, 1'b1);
      pend = 1'b1; pend_seq = seq3[exp_w]; pend_wen = wen3[exp_w];
      mptr = (exp_w == 2'd2) ? 2'd0 : exp_w + 2'd1;
      @(posedge clk); #1;
    end
    v3 = '0;
    @(negedge clk);
    chk("rand last cseq", cseq3, pend_seq);
    chk("rand last cwen", cwen3, pend_wen);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/complete_arbiter.md
Name: complete_arbiter

Overview:
- Shares the single completion/writeback channel between `p_num_pipes` execute pipes.
- The channel feeds the regfile write port and the rename table's pending-clear.
- Per-pipe val/rdy requests are round-robin arbitrated; one winner per cycle is registered onto the completion broadcast.
- Sits between the X-stage pipe outputs and the `CompleteNotif` publisher consumed by the decode/issue unit.

Parameters:
- `p_num_pipes`, 2, number of requesting execute pipes (≥1).
- `p_seq_num_bits`, 5, width of instruction sequence numbers.
- `p_num_phys_regs`, 36, physical register count; `p_phys_addr_bits = $clog2(p_num_phys_regs)`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `req_val`  in  `p_num_pipes`  pipe i has a completed instruction
- `req_rdy`  out  `p_num_pipes`  pipe i granted this cycle
- `req_seq_num`  in  `p_num_pipes` x `p_seq_num_bits`  per-pipe sequence number
- `req_preg`  in  `p_num_pipes` x `p_phys_addr_bits`  per-pipe destination physical reg
- `req_waddr`  in  `p_num_pipes` x 5  per-pipe architectural destination
- `req_wdata`  in  `p_num_pipes` x 32  per-pipe writeback data
- `req_wen`  in  `p_num_pipes`  per-pipe write enable
- `complete_val`  out  1  completion broadcast valid
- `complete_seq_num`  out  `p_seq_num_bits`  granted seq_num
- `complete_preg`  out  `p_phys_addr_bits`  granted preg
- `complete_waddr`  out  5  granted waddr
- `complete_wdata`  out  32  granted wdata
- `complete_wen`  out  1  granted wen

Behaviour:
- One clock `clk`; reset `rst` is synchronous, active-high.
- **State:**
  - Round-robin priority pointer `ptr`, width `$clog2(p_num_pipes)` (min 1 bit).
  - Output register holding the `complete_*` fields.
- **Reset:**
  - `ptr` = 0.
  - `complete_val` = 0; `complete_wen` = 0.
  - Other `complete_*` fields are don't-care (X allowed).
- **Grant (combinational):**
  - Search from index `ptr` upward, wrapping modulo `p_num_pipes`.
  - The first i with `req_val[i]=1` gets `req_rdy[i]=1`; all other `req_rdy` bits are 0.
  - `req_rdy` is one-hot or zero.
  - `req_rdy[i]` may depend on `req_val`. Pipes must not make `req_val` depend on `req_rdy`.
  - Transfer for pipe i = `req_val[i] & req_rdy[i]`.
- **Pointer update:**
  - On a transfer by pipe g, `ptr` <= (g+1) mod `p_num_pipes` at the next edge.
  - No transfer: `ptr` holds.
  - The wrap from `p_num_pipes-1` goes to 0. For non-power-of-2 counts the pointer never takes illegal values.
- **Latency:**
  - A transfer at edge-cycle t drives the `complete_*` outputs during cycle t+1 with that pipe's fields.
  - `complete_val=1` and `complete_wen = req_wen[g]`.
- **Idle cycles:**
  - No request in cycle t means `complete_val=0` and `complete_wen=0` in t+1.
  - Data fields are don't-care.
- **Back-to-back:** a new winner each cycle is allowed. The output register is overwritten every cycle; there is no output backpressure, because the broadcast is always accepted.
- **Fairness:** a continuously asserted `req_val[i]` is granted within `p_num_pipes` cycles.
- **Degenerate cases:**
  - `p_num_pipes=1`: `req_rdy[0] = req_val[0]`, `ptr` constant 0.
  - Requests with `req_wen=0` (e.g. branches, stores) are still arbitrated and broadcast, so seq-num completion is visible.
- **Reset mid-operation:** `rst` dominates any transfer in the same cycle. `req_rdy` is forced to 0 while `rst=1`, so no pipe sees a transfer during reset.
- **Line trace:** shows the granted pipe index and seq_num, or blanks when idle.

Test Plan:
- Reset, then pipe0 raises `req_val` with seq 3, preg 10, wdata 0xDEADBEEF, wen 1 -> `req_rdy=2'b01` that cycle. The next cycle shows `complete_val=1`, seq 3, preg 10, wdata 0xDEADBEEF, wen 1; the following idle cycle shows `complete_val=0`.
- N=2, both pipes request continuously for 4 cycles starting with `ptr=0` -> grants in order 0,1,0,1. The `complete_seq_num` stream matches one cycle later.
- N=3, only pipe2 requests after pipe0 was granted (`ptr=1`) -> pipe2 is granted and `ptr` becomes 0. Pipe1 then requesting together with pipe0 -> pipe0 wins.
- Pipe1 requests with wen 0, seq 7 -> `complete_val=1`, `complete_wen=0`, seq 7 next cycle.
- Assert `rst` while both pipes request -> `req_rdy=0` during reset. After reset, `complete_val=0` and the first grant goes to pipe0.
- N=3, pipe1 holds `req_val` high while pipes 0 and 2 toggle randomly for 1000 cycles -> pipe1 is never waiting more than 3 cycles. Every transfer appears on `complete_*` exactly once, one cycle later.
